// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared transaction-layer constants and egress state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int CNT_WIDTH  = 5;
  localparam int NUM_PORTS  = 4;
  localparam int TAG_WIDTH  = 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/egress_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : egress_skid_buf
// Description : Two-entry tagged output buffer. The head entry is the link
//               output register; the tail absorbs one word while the link
//               stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_skid_buf
  import tl_pkg::*;
#(
  parameter int DATA_WIDTH = tl_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [TAG_WIDTH-1:0]  head_tag,
  output logic [1:0]            entries
);

  logic                  r_head_valid;
  logic [TAG_WIDTH-1:0]  r_head_tag;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic                  r_tail_valid;
  logic [TAG_WIDTH-1:0]  r_tail_tag;
  logic [DATA_WIDTH-1:0] r_tail_data;
  logic                  w_deq;

  assign w_deq     = r_head_valid && ready;
  assign data_out  = r_head_data;
  assign valid_out = r_head_valid;
  assign head_tag  = r_head_tag;
  assign entries   = {1'b0, r_head_valid} + {1'b0, r_tail_valid};

  // Head advances when free or accepted; otherwise an arriving word parks in the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      r_head_valid <= 1'b0;
      r_head_tag   <= '0;
      r_head_data  <= '0;
      r_tail_valid <= 1'b0;
      r_tail_tag   <= '0;
      r_tail_data  <= '0;
    end else if (!r_head_valid || w_deq) begin
      if (r_tail_valid) begin
        r_head_valid <= 1'b1;
        r_head_tag   <= r_tail_tag;
        r_head_data  <= r_tail_data;
        r_tail_valid <= push;
        if (push) begin
          r_tail_tag  <= push_tag;
          r_tail_data <= push_data;
        end
      end else begin
        r_head_valid <= push;
        if (push) begin
          r_head_tag  <= push_tag;
          r_head_data <= push_data;
        end
      end
    end else if (push) begin
      r_tail_valid <= 1'b1;
      r_tail_tag   <= push_tag;
      r_tail_data  <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tl_egress_arbiter
// Description : Round-robin reader of four output-port FIFOs onto one
//               valid/ready link, with per-port delivered-word counters and a
//               req/idx counter query port.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_egress_arbiter
  import tl_pkg::*;
#(
  parameter int DATA_WIDTH = tl_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = tl_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  emptyP0,
  input  logic                  emptyP1,
  input  logic                  emptyP2,
  input  logic                  emptyP3,
  input  logic [DATA_WIDTH-1:0] dataInP0,
  input  logic [DATA_WIDTH-1:0] dataInP1,
  input  logic [DATA_WIDTH-1:0] dataInP2,
  input  logic [DATA_WIDTH-1:0] dataInP3,
  output logic                  popP0,
  output logic                  popP1,
  output logic                  popP2,
  output logic                  popP3,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  input  logic                  readyIn,
  input  logic                  req,
  input  logic [2:0]            idx,
  output logic [CNT_WIDTH-1:0]  counterOut,
  output logic                  counterValid,
  output logic                  idle
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [NUM_PORTS-1:0]   w_empty;
  logic [NUM_PORTS-1:0]   w_eligible;
  logic [DATA_WIDTH-1:0]  w_data_in [NUM_PORTS];
  logic                   r_inflight;
  logic [TAG_WIDTH-1:0]   r_inflight_port;
  logic [TAG_WIDTH-1:0]   r_ptr;
  logic [CNT_WIDTH-1:0]   r_cnt [NUM_PORTS];
  logic [1:0]             w_entries;
  logic [TAG_WIDTH-1:0]   w_head_tag;
  logic                   w_deq;
  logic                   w_credit;
  logic                   w_grant_vld;
  logic [TAG_WIDTH-1:0]   w_grant;
  logic                   w_pop;

  assign w_empty      = {emptyP3, emptyP2, emptyP1, emptyP0};
  assign w_data_in[0] = dataInP0;
  assign w_data_in[1] = dataInP1;
  assign w_data_in[2] = dataInP2;
  assign w_data_in[3] = dataInP3;

  // The FIFO empty flags already reflect last cycle's pop, so a port popped
  // last cycle only stays eligible when its empty flag is still low.
  assign w_eligible = ~w_empty;

  assign w_deq = validOut && readyIn;

  // Pop only if the word can land: occupancy after this edge's delivery stays below 2.
  assign w_credit = ({1'b0, w_entries} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_deq});
  assign w_pop    = (r_state != ST_INIT) && !init && w_credit && w_grant_vld;

  assign popP0 = w_pop && (w_grant == 2'd0);
  assign popP1 = w_pop && (w_grant == 2'd1);
  assign popP2 = w_pop && (w_grant == 2'd2);
  assign popP3 = w_pop && (w_grant == 2'd3);

  assign idle = (r_state == ST_IDLE) && (w_entries == 2'd0) && !r_inflight;

  // Round-robin search from the pointer; lowest offset from the pointer wins.
  always_comb begin
    logic [TAG_WIDTH-1:0] cand;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    cand        = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = r_ptr + TAG_WIDTH'(i);
      if (w_eligible[cand]) begin
        w_grant_vld = 1'b1;
        w_grant     = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_next_state;
  end

  // Next-state logic; init overrides every state.
  always_comb begin
    w_next_state = r_state;
    if (init) begin
      w_next_state = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:   w_next_state = ST_IDLE;
        ST_IDLE:   if (|w_eligible) w_next_state = ST_ACTIVE;
        ST_ACTIVE: if ((&w_empty) && (w_entries == 2'd0) && !r_inflight) w_next_state = ST_IDLE;
        default:   w_next_state = ST_INIT;
      endcase
    end
  end

  // Track the pop whose data arrives next cycle and advance the rotation pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight      <= 1'b0;
      r_inflight_port <= '0;
      r_ptr           <= '0;
    end else if (init) begin
      r_inflight      <= 1'b0;
      r_inflight_port <= '0;
      r_ptr           <= '0;
    end else begin
      r_inflight <= w_pop;
      if (w_pop) begin
        r_inflight_port <= w_grant;
        r_ptr           <= w_grant + 2'd1;
      end
    end
  end

  egress_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (init),
    .push      (r_inflight),
    .push_tag  (r_inflight_port),
    .push_data (w_data_in[r_inflight_port]),
    .ready     (readyIn),
    .data_out  (dataOut),
    .valid_out (validOut),
    .head_tag  (w_head_tag),
    .entries   (w_entries)
  );

  // Count words at the moment the link accepts them; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || init) begin
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= '0;
    end else if (w_deq) begin
      r_cnt[w_head_tag] <= r_cnt[w_head_tag] + CNT_WIDTH'(1);
    end
  end

  // Query port: one-cycle response with the pre-increment count; ignored in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || init) begin
      counterValid <= 1'b0;
      counterOut   <= '0;
    end else if (r_state == ST_INIT) begin
      counterValid <= 1'b0;
    end else begin
      counterValid <= req;
      if (req) counterOut <= idx[2] ? '0 : r_cnt[idx[1:0]];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_egress_arbiter
// Description : Directed self-checking bench for tl_egress_arbiter with a
//               behavioural model of the four output-port FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_egress_arbiter;
  localparam int DW = 12;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, init, readyIn, req;
  logic [2:0]    idx;
  logic          emptyP0, emptyP1, emptyP2, emptyP3;
  logic [DW-1:0] dataInP0, dataInP1, dataInP2, dataInP3;
  logic          popP0, popP1, popP2, popP3;
  logic [DW-1:0] dataOut;
  logic          validOut;
  logic [CW-1:0] counterOut;
  logic          counterValid;
  logic          idle;

  always #5 clk = ~clk;

  tl_egress_arbiter dut (
    .clk(clk), .reset(reset), .init(init),
    .emptyP0(emptyP0), .emptyP1(emptyP1), .emptyP2(emptyP2), .emptyP3(emptyP3),
    .dataInP0(dataInP0), .dataInP1(dataInP1), .dataInP2(dataInP2), .dataInP3(dataInP3),
    .popP0(popP0), .popP1(popP1), .popP2(popP2), .popP3(popP3),
    .dataOut(dataOut), .validOut(validOut), .readyIn(readyIn),
    .req(req), .idx(idx), .counterOut(counterOut), .counterValid(counterValid),
    .idle(idle)
  );

  // FIFO model: registered empty flag and read data, both updated the cycle after a pop.
  logic [DW-1:0] fq [4][$];
  logic [DW-1:0] fd [4] = '{default: '0};
  logic [3:0]    fe     = 4'hF;
  logic [3:0]    pop_s  = 4'h0;

  assign emptyP0 = fe[0];
  assign emptyP1 = fe[1];
  assign emptyP2 = fe[2];
  assign emptyP3 = fe[3];
  assign dataInP0 = fd[0];
  assign dataInP1 = fd[1];
  assign dataInP2 = fd[2];
  assign dataInP3 = fd[3];

  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (pop_s[p] && fq[p].size() > 0) fd[p] <= fq[p].pop_front();
      fe[p] <= (fq[p].size() == 0);
    end
  end

  // Mid-cycle monitor: pops and accepted link words with their cycle numbers.
  int          cyc = 0;
  int          multi_pop = 0;
  logic [3:0]  pv;
  int          pop_port [$];
  int          pop_cyc  [$];
  int          rx       [$];
  int          rx_cyc   [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pv = {popP3, popP2, popP1, popP0};
    if ($countones(pv) > 1) multi_pop++;
    for (int p = 0; p < 4; p++) begin
      if (pv[p]) begin
        pop_port.push_back(p);
        pop_cyc.push_back(cyc);
      end
    end
    if (validOut && readyIn) begin
      rx.push_back(int'(dataOut));
      rx_cyc.push_back(cyc);
    end
    pop_s = pv;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int p, input int base, input int n);
    for (int k = 0; k < n; k++) fq[p].push_back(DW'(base + k));
  endtask

  task automatic clear_logs();
    pop_port.delete();
    pop_cyc.delete();
    rx.delete();
    rx_cyc.delete();
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, rx.size(), n);
  endtask

  task automatic query(input string tag, input int sel, input int exp);
    req = 1'b1;
    idx = 3'(sel);
    step(1);
    chk({tag, "_valid"}, counterValid, 1);
    chk(tag, counterOut, exp);
  endtask

  task automatic init_pulse();
    init = 1'b1;
    step(1);
    init = 1'b0;
    step(1);
  endtask

  initial begin
    reset = 1'b1; init = 1'b1; readyIn = 1'b0; req = 1'b0; idx = 3'd0;

    // Reset values
    step(3);
    chk("rst_pops", {popP3, popP2, popP1, popP0}, 0);
    chk("rst_dataOut", dataOut, 0);
    chk("rst_validOut", validOut, 0);
    chk("rst_counterOut", counterOut, 0);
    chk("rst_counterValid", counterValid, 0);
    chk("rst_idle", idle, 0);
    reset = 1'b0;
    step(2);
    chk("init_idle", idle, 0);
    init = 1'b0;
    step(1);
    chk("idle_after_init", idle, 1);

    // Single port burst: P0 words 1..7
    clear_logs();
    readyIn = 1'b1;
    load(0, 1, 7);
    wait_rx("t1_rx_count", 7, 30);
    chk("t1_npops", pop_port.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk("t1_data", rx[i], i + 1);
      chk("t1_pop_port", pop_port[i], 0);
      chk("t1_pop_cycle", pop_cyc[i] - pop_cyc[0], i);
    end
    chk("t1_latency", rx_cyc[0] - pop_cyc[0], 2);
    step(2);
    chk("t1_idle", idle, 1);
    query("t1_cnt0", 0, 7);
    req = 1'b0;
    step(1);
    chk("t1_cv_drop", counterValid, 0);

    // Round robin over four ports, two words each
    init_pulse();
    clear_logs();
    for (int p = 0; p < 4; p++) load(p, 100 + 10 * p, 2);
    wait_rx("t2_rx_count", 8, 30);
    for (int i = 0; i < 8; i++) begin
      chk("t2_grant", pop_port[i], i % 4);
      chk("t2_data", rx[i], 100 + 10 * (i % 4) + i / 4);
    end
    step(2);
    for (int p = 0; p < 4; p++) query("t2_cnt", p, 2);
    req = 1'b0;
    step(1);
    chk("t2_cv_drop", counterValid, 0);

    // Back-pressure with P2 holding 6 words
    clear_logs();
    readyIn = 1'b0;
    load(2, 200, 6);
    step(8);
    chk("t3_npops_stall", pop_port.size(), 2);
    chk("t3_valid_stall", validOut, 1);
    chk("t3_data_stall", dataOut, 200);
    step(3);
    chk("t3_npops_hold", pop_port.size(), 2);
    chk("t3_data_hold", dataOut, 200);
    readyIn = 1'b1;
    wait_rx("t3_rx_count", 6, 30);
    for (int i = 0; i < 6; i++) chk("t3_data", rx[i], 200 + i);
    step(3);
    chk("t3_npops_total", pop_port.size(), 6);
    chk("t3_rx_total", rx.size(), 6);

    // Counter wrap: 33 words from P1
    init_pulse();
    clear_logs();
    load(1, 300, 33);
    wait_rx("t4_rx_count", 33, 80);
    chk("t4_last_word", rx[32], 332);
    step(2);
    query("t4_cnt1_wrap", 1, 1);
    query("t4_idx5", 5, 0);
    req = 1'b0;
    step(1);
    chk("t4_cv_drop", counterValid, 0);

    // init with two words buffered
    clear_logs();
    readyIn = 1'b0;
    load(3, 400, 4);
    step(6);
    chk("t5_valid_before", validOut, 1);
    chk("t5_data_before", dataOut, 400);
    clear_logs();
    init = 1'b1;
    req = 1'b1;
    idx = 3'd3;
    step(1);
    chk("t5_valid_flush", validOut, 0);
    chk("t5_cv_in_init", counterValid, 0);
    step(2);
    chk("t5_cv_in_init_hold", counterValid, 0);
    init = 1'b0;
    req = 1'b0;
    step(1);
    chk("t5_no_pops_init", pop_port.size(), 0);
    query("t5_cnt3_cleared", 3, 0);
    req = 1'b0;
    readyIn = 1'b1;
    wait_rx("t5_rx_count", 2, 20);
    chk("t5_rx0", rx[0], 402);
    chk("t5_rx1", rx[1], 403);
    step(2);
    query("t5_cnt3_after", 3, 2);
    req = 1'b0;
    step(1);

    chk("onehot_pops", multi_pop, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
